// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: state
// encoding and the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic int CNT_W(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_mult_nbit_if.sv
// Start/ready/done handshake bundle between a requester and seq_mult_nbit.
interface seq_mult_nbit_if #(
    parameter int N = 8
);
    logic           start;
    logic           clear;
    logic           is_signed;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, clear, is_signed, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, clear, is_signed, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/addsub_nbit.sv
// Plain W-bit ripple adder with carry-in and carry-out.
module addsub_nbit #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_mult_nbit.sv
// Iterative N x N shift-and-add multiplier, one partial product per clock,
// with optional two's-complement operation via sign-magnitude conversion.
module seq_mult_nbit
    import mult_pkg::*;
#(
    parameter int N         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_mult_nbit_if.slave bus
);

    localparam int CW = CNT_W(N);

    state_t         state;
    state_t         state_nx;
    logic [N:0]     acc_hi;
    logic [N-1:0]   acc_lo;
    logic [N-1:0]   mcand;
    logic           sgn;
    logic [CW-1:0]  cnt;
    logic           done_q;
    logic [2*N-1:0] product_q;

    logic           accept;
    logic           last;
    logic           signed_mode;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [N:0]     addend;
    logic [N:0]     sum;
    logic           cout;
    logic [2*N-1:0] acc;

    assign accept      = (state == ST_IDLE) && bus.start && !bus.clear;
    assign last        = (cnt == CW'(N - 1));
    assign signed_mode = SIGNED_EN && bus.is_signed;
    assign mag_a       = (signed_mode && bus.a[N-1]) ? -bus.a : bus.a;
    assign mag_b       = (signed_mode && bus.b[N-1]) ? -bus.b : bus.b;
    assign addend      = acc_lo[0] ? {1'b0, mcand} : '0;
    assign acc         = {acc_hi[N-1:0], acc_lo};

    addsub_nbit #(.W(N + 1)) u_add (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_CALC;
            ST_CALC: begin
                if (bus.clear)  state_nx = ST_IDLE;
                else if (last)  state_nx = ST_FIX;
            end
            ST_FIX:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // The carry-out never sets (acc_hi + mcand < 2^(N+1)), so it doubles as the zero fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            sgn       <= 1'b0;
            cnt       <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sgn    <= signed_mode && (bus.a[N-1] ^ bus.b[N-1]);
                        mcand  <= mag_a;
                        acc_hi <= '0;
                        acc_lo <= mag_b;
                        cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    if (!bus.clear) begin
                        acc_hi <= {cout, sum[N:1]};
                        acc_lo <= {sum[0], acc_lo[N-1:1]};
                        cnt    <= cnt + CW'(1);
                    end
                end
                ST_FIX: begin
                    if (!bus.clear) begin
                        product_q <= sgn ? -acc : acc;
                        done_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready   = (state == ST_IDLE);
    assign bus.busy    = (state == ST_CALC) || (state == ST_FIX);
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_nbit.sv
// Directed bench for seq_mult_nbit: a vector table plus hand-written
// sequences for busy-start, back-to-back, async reset and clear.
module tb_seq_mult_nbit;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_mult_nbit_if #(.N(N)) bus_s ();
    seq_mult_nbit_if #(.N(N)) bus_u ();

    seq_mult_nbit #(.N(N), .SIGNED_EN(1'b1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    seq_mult_nbit #(.N(N), .SIGNED_EN(1'b0)) dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_u)
    );

    typedef struct {
        bit          sel;
        logic        sg;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic sg, input logic [7:0] av, input logic [7:0] bv);
        if (sel) begin
            bus_u.start = st; bus_u.is_signed = sg; bus_u.a = av; bus_u.b = bv;
        end else begin
            bus_s.start = st; bus_s.is_signed = sg; bus_s.a = av; bus_s.b = bv;
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus_u.start = v;
        else     bus_s.start = v;
    endtask

    task automatic set_clear(input bit sel, input logic v);
        if (sel) bus_u.clear = v;
        else     bus_s.clear = v;
    endtask

    function automatic logic get_done(input bit sel);
        return sel ? bus_u.done : bus_s.done;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? bus_u.ready : bus_s.ready;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? bus_u.busy : bus_s.busy;
    endfunction

    function automatic logic [15:0] get_prod(input bit sel);
        return sel ? bus_u.product : bus_s.product;
    endfunction

    // Called just after a falling edge; start is accepted on the next rising edge.
    task automatic apply_stimulus(input bit sel, input logic sg, input logic [7:0] av, input logic [7:0] bv);
        drive(sel, 1'b1, sg, av, bv);
    endtask

    // Returns the falling-edge index (1 = first after the accept edge) where done is seen, or -1.
    task automatic wait_done(input bit sel, input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (i == 1) set_start(sel, 1'b0);
            if (get_done(sel)) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic clear_in_fix(input bit sel, input logic sg, input logic [7:0] av, input logic [7:0] bv,
                                input logic [15:0] prev, input string tag);
        int pulses;
        apply_stimulus(sel, sg, av, bv);
        for (int i = 1; i <= N + 1; i++) begin
            @(negedge clk);
            if (i == 1) set_start(sel, 1'b0);
        end
        check_output({tag, "_busy_in_fix"}, 32'(get_busy(sel)), 32'd1);
        set_clear(sel, 1'b1);
        @(negedge clk);
        set_clear(sel, 1'b0);
        check_output({tag, "_done_after_clear"}, 32'(get_done(sel)), 32'd0);
        check_output({tag, "_ready_after_clear"}, 32'(get_ready(sel)), 32'd1);
        check_output({tag, "_product_kept"}, 32'(get_prod(sel)), 32'(prev));
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (get_done(sel)) pulses++;
        end
        check_output({tag, "_no_late_done"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        bit held_ok;
        logic [15:0] first_prod;

        vecs[0]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{1'b0, 1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2]  = '{1'b0, 1'b1, 8'h80, 8'h01, 16'hFF80};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h80, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 8'hFF, 8'h02, 16'hFFFE};
        vecs[5]  = '{1'b0, 1'b1, 8'h05, 8'hFD, 16'hFFF1};
        vecs[6]  = '{1'b0, 1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[7]  = '{1'b0, 1'b0, 8'h80, 8'hFF, 16'h7F80};
        vecs[8]  = '{1'b1, 1'b1, 8'h80, 8'hFF, 16'h7F80};
        vecs[9]  = '{1'b1, 1'b1, 8'hFF, 8'h02, 16'h01FE};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 8'hFF, 16'h0000};
        vecs[11] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 16'h0001};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_clear(1'b0, 1'b0);
        set_clear(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_output("reset_ready", 32'(bus_s.ready), 32'd1);
        check_output("reset_busy", 32'(bus_s.busy), 32'd0);
        check_output("reset_done", 32'(bus_s.done), 32'd0);
        check_output("reset_product", 32'(bus_s.product), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].sel, vecs[i].sg, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].sel, 30, cyc);
            check_output($sformatf("vec%0d_latency", i), 32'(cyc), 32'(N + 2));
            check_output($sformatf("vec%0d_product", i), 32'(get_prod(vecs[i].sel)), 32'(vecs[i].exp));
            check_output($sformatf("vec%0d_ready_in_done", i), 32'(get_ready(vecs[i].sel)), 32'd1);
            @(negedge clk);
            check_output($sformatf("vec%0d_done_width", i), 32'(get_done(vecs[i].sel)), 32'd0);
        end

        // Start pulsed while busy must be ignored
        apply_stimulus(1'b0, 1'b0, 8'd10, 8'd11);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) set_start(1'b0, 1'b0);
        end
        check_output("busy_start_busy", 32'(bus_s.busy), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 8'd2, 8'd2);
        pulses = 0;
        first_prod = '0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1) drive(1'b0, 1'b0, 1'b0, 8'd99, 8'd77);
            if (bus_s.done) begin
                pulses++;
                first_prod = bus_s.product;
            end
        end
        check_output("busy_start_pulses", 32'(pulses), 32'd1);
        check_output("busy_start_product", 32'(first_prod), 32'h006E);

        // Start asserted in the done cycle: back-to-back operation
        apply_stimulus(1'b0, 1'b0, 8'd7, 8'd6);
        wait_done(1'b0, 30, cyc);
        check_output("b2b_first_product", 32'(bus_s.product), 32'h002A);
        drive(1'b0, 1'b1, 1'b0, 8'd3, 8'd5);
        held_ok = 1'b1;
        cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) set_start(1'b0, 1'b0);
            if (bus_s.done) begin
                cyc = i;
                break;
            end
            if (bus_s.product !== 16'h002A) held_ok = 1'b0;
        end
        check_output("b2b_product_held", 32'(held_ok), 32'd1);
        check_output("b2b_second_latency", 32'(cyc), 32'(N + 2));
        check_output("b2b_second_product", 32'(bus_s.product), 32'h000F);
        @(negedge clk);

        // Asynchronous reset mid-CALC
        apply_stimulus(1'b0, 1'b0, 8'd12, 8'd12);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) set_start(1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        check_output("async_rst_product", 32'(bus_s.product), 32'd0);
        check_output("async_rst_ready", 32'(bus_s.ready), 32'd1);
        check_output("async_rst_busy", 32'(bus_s.busy), 32'd0);
        check_output("async_rst_done", 32'(bus_s.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_s.done) pulses++;
        end
        check_output("async_rst_no_done", 32'(pulses), 32'd0);
        apply_stimulus(1'b0, 1'b0, 8'd12, 8'd12);
        wait_done(1'b0, 30, cyc);
        check_output("post_rst_latency", 32'(cyc), 32'(N + 2));
        check_output("post_rst_product", 32'(bus_s.product), 32'h0090);
        @(negedge clk);

        // Clear during FIX, on both instances
        clear_in_fix(1'b0, 1'b1, 8'hFD, 8'h03, 16'h0090, "clr_s");
        apply_stimulus(1'b1, 1'b1, 8'h80, 8'hFF);
        wait_done(1'b1, 30, cyc);
        check_output("clr_u_setup_product", 32'(bus_u.product), 32'h7F80);
        @(negedge clk);
        clear_in_fix(1'b1, 1'b1, 8'hFF, 8'h02, 16'h7F80, "clr_u");
        apply_stimulus(1'b1, 1'b1, 8'hFF, 8'h02);
        wait_done(1'b1, 30, cyc);
        check_output("clr_u_rerun_latency", 32'(cyc), 32'(N + 2));
        check_output("clr_u_rerun_product", 32'(bus_u.product), 32'h01FE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_mult_nbit.md
Name: seq_mult_nbit

Overview:
Iterative shift-and-add multiplier that takes two N-bit operands and returns a 2N-bit product, one partial product per clock, through a start/ready/done handshake. It replaces the purely combinational adder-array datapath in the multiplier project with a small-area sequential engine. Each instance contains a single (N+1)-bit adder and supports unsigned or two's-complement operation, selected per operation.

Parameters:
N, 8, operand width in bits; legal range 2..32; product width is 2N
SIGNED_EN, 1, 1 = is_signed input honoured; 0 = is_signed ignored and every operation is unsigned

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset; one clock domain, no other clocks
start  input  1  request; accepted on a rising edge only when start=1 and ready=1
clear  input  1  synchronous abort; returns to IDLE, product unchanged
is_signed  input  1  sampled with start; 1 = two's-complement operands and product
a  input  N  multiplicand; sampled on the accepting edge only
b  input  N  multiplier; sampled on the accepting edge only
ready  output  1  high in IDLE; accept window
busy  output  1  high in CALC and FIX
done  output  1  single-cycle pulse; product valid and newly updated
product  output  2N  result register; holds its value until the next completion

Behaviour:
- Reset (rst_n=0, async): state=IDLE, ready=1, busy=0, done=0, product=0, all internal registers cleared. Reset mid-operation discards the operation; no done pulse is produced.
- States:
  - IDLE -> CALC on start&ready.
  - CALC -> FIX after N iterations.
  - FIX -> IDLE after one cycle.
  - clear=1 in CALC or FIX -> IDLE, with no done pulse and product unchanged. clear has priority over start. clear in IDLE does nothing.
- Accept edge, in IDLE with start=1:
  - sgn = SIGNED_EN & is_signed & (a[N-1]^b[N-1]).
  - mcand = |a| and mplr = |b| when signed mode is active; otherwise the raw operands.
  - Magnitudes are N-bit unsigned, so the most negative value maps to 2^(N-1). Example: -128 -> 0x80.
  - acc_hi (N+1 bits) = 0, acc_lo (N bits) = mplr, cnt = 0.
- CALC, one iteration per edge:
  - If acc_lo[0]=1, sum = acc_hi + mcand; otherwise sum = acc_hi.
  - Then {acc_hi, acc_lo} = {sum, acc_lo} >> 1, with zero fill.
  - cnt increments; after the edge where cnt reaches N-1, go to FIX.
- FIX edge:
  - product = sgn ? -(acc[2N-1:0]) : acc[2N-1:0], two's-complement negation.
  - done=1 for the following cycle; state=IDLE.
- Latency:
  - Accept at edge E0; done is high in the cycle after edge E(N+1); total N+1 clocks.
  - done and ready are both high in that cycle.
  - Throughput is one result per N+1 clocks when back-to-back.
- start while busy is ignored, with no queuing; a and b may change freely while busy.
- A start asserted during the done cycle is accepted. product keeps the previous result until the new FIX edge.
- Width rules: no overflow is possible. An unsigned N×N product fits in 2N bits. In signed mode, (-2^(N-1))² = 2^(2N-2) fits as a positive 2N-bit value.
- Zero operand: the full latency still applies; product=0 and is never negated to a nonzero value.

Decomposition:
- Shared package mult_pkg:
  - state encoding constants ST_IDLE, ST_CALC, ST_FIX (2 bits).
  - the CNT_W = clog2(N) function.
- One natural sub-module, addsub_nbit: a parametrised (N+1)-bit adder with carry-in and carry-out.
  - Used for the iteration add.
  - Can optionally be reused for the FIX negation (invert plus cin=1) to keep a single adder.
- The controller and datapath shift register stay in seq_mult_nbit.

Test Plan:
1. N=8, unsigned, a=255, b=255, start for 1 cycle -> done pulses exactly 9 clocks after the accept edge; product=0xFE01; ready=1 in the done cycle.
2. N=8, signed, a=0x80 (-128), b=0x80 -> product=0x4000. Then a=0x80, b=0x01 -> product=0xFF80. Then a=0x00, b=0x80 -> product=0x0000.
3. Start pulsed again 3 cycles into an operation with different operands -> ignored; exactly one done pulse; result from the first operands only.
4. Start asserted in the done cycle of 7×6 (result 0x002A) with new operands 3×5 -> 0x002A held until the second done; then 0x000F.
5. rst_n low for 1 cycle, asynchronously mid-CALC -> outputs go to reset values immediately; no done pulse; next operation 12×12 -> 0x0090.
6. clear high during FIX -> no done pulse; product keeps its prior value; ready=1 next cycle. Repeat with SIGNED_EN=0 and is_signed=1, a=0xFF, b=0x02 -> 0x01FE (unsigned).
